adder_4bit_unit: RTL and testbench



---
 rtl/adder_4bit_unit_if.sv | 34 +++
 rtl/adder_4bit_unit.sv | 66 ++++++
 tb/tb_adder_4bit_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_4bit_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_4bit_unit_if
// Purpose  : Operand/result bundle for the 4-bit adder unit.
// Revision : 1.0 - initial release
// ============================================================================
interface adder_4bit_unit_if;
   logic [3:0] i_a;
   logic [3:0] i_b;
   logic       i_cin;
   logic       i_en;
   logic [3:0] o_sum;
   logic       o_cout;
   logic       o_ovf;
   logic       o_p;
   logic       o_g;
   logic [3:0] o_sum_q;
   logic       o_cout_q;
   logic       o_ovf_q;
   logic       o_vld_q;

   modport master (
      output i_a, i_b, i_cin, i_en,
      input  o_sum, o_cout, o_ovf, o_p, o_g,
      input  o_sum_q, o_cout_q, o_ovf_q, o_vld_q
   );

   modport slave (
      input  i_a, i_b, i_cin, i_en,
      output o_sum, o_cout, o_ovf, o_p, o_g,
      output o_sum_q, o_cout_q, o_ovf_q, o_vld_q
   );
endinterface
`default_nettype wire

// File: rtl/adder_4bit_unit.sv
`default_nettype none
// ============================================================================
// Module   : adder_4bit_unit
// Purpose  : Ripple-carry 4-bit adder with group P/G and a registered result.
// Revision : 1.0 - initial release
// ============================================================================
module adder_4bit_unit (
   input  wire logic         i_clk,
   input  wire logic         i_rst_n,
   adder_4bit_unit_if.slave  bus
);

   logic [4:0] w_c;
   logic [3:0] w_s;
   logic [3:0] w_p;
   logic [3:0] w_g;

   logic [3:0] r_sum;
   logic       r_cout;
   logic       r_ovf;
   logic       r_vld;

   assign w_c[0] = bus.i_cin;

   generate
      for (genvar k = 0; k < 4; k++) begin : g_fa
         assign w_p[k]   = bus.i_a[k] ^ bus.i_b[k];
         assign w_g[k]   = bus.i_a[k] & bus.i_b[k];
         assign w_s[k]   = w_p[k] ^ w_c[k];
         assign w_c[k+1] = w_g[k] | (w_c[k] & w_p[k]);
      end
   endgenerate

   assign bus.o_sum  = w_s;
   assign bus.o_cout = w_c[4];
   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   assign bus.o_ovf  = w_c[3] ^ w_c[4];
   assign bus.o_p    = &w_p;
   assign bus.o_g    = w_g[3]
                     | (w_p[3] & w_g[2])
                     | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum  <= 4'd0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_vld  <= 1'b0;
      end else if (bus.i_en) begin
         r_sum  <= w_s;
         r_cout <= w_c[4];
         r_ovf  <= w_c[3] ^ w_c[4];
         r_vld  <= 1'b1;
      end else begin
         r_vld  <= 1'b0;
      end
   end

   assign bus.o_sum_q  = r_sum;
   assign bus.o_cout_q = r_cout;
   assign bus.o_ovf_q  = r_ovf;
   assign bus.o_vld_q  = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_adder_4bit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_4bit_unit
// Purpose  : Scoreboard bench for adder_4bit_unit (combinational and registered).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_4bit_unit;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
      logic       p;
      logic       g;
   } comb_t;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       ovf;
   } reg_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   comb_t comb_q[$];
   reg_t  reg_q[$];

   adder_4bit_unit_if bus ();

   adder_4bit_unit dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (a=%h b=%h cin=%b)",
                  name, act, exp, bus.i_a, bus.i_b, bus.i_cin);
      end
   endtask

   // Independent reference: arithmetic sum and signed-range overflow test.
   function automatic comb_t model(input logic [3:0] a, input logic [3:0] b, input logic cin);
      comb_t r;
      logic [4:0] t;
      int sa, sb, ss;
      t  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      sa = a[3] ? int'(a) - 16 : int'(a);
      sb = b[3] ? int'(b) - 16 : int'(b);
      ss = sa + sb + int'(cin);
      r.sum  = t[3:0];
      r.cout = t[4];
      r.ovf  = (ss > 7) || (ss < -8);
      r.p    = ((a ^ b) == 4'hF);
      r.g    = ({1'b0, a} + {1'b0, b}) > 5'd15;
      return r;
   endfunction

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic en, input comb_t exp);
      reg_t re;
      @(posedge clk);
      #1;
      bus.i_a   = a;
      bus.i_b   = b;
      bus.i_cin = cin;
      bus.i_en  = en;
      comb_q.push_back(exp);
      if (en) begin
         re.sum  = exp.sum;
         re.cout = exp.cout;
         re.ovf  = exp.ovf;
         reg_q.push_back(re);
      end
   endtask

   // Monitor: combinational result of this cycle, registered result when valid.
   always @(negedge clk) begin
      comb_t ec;
      reg_t  er;
      if (comb_q.size() > 0) begin
         ec = comb_q.pop_front();
         chk("comb_sum",  {4'd0, bus.o_sum},  {4'd0, ec.sum});
         chk("comb_cout", {7'd0, bus.o_cout}, {7'd0, ec.cout});
         chk("comb_ovf",  {7'd0, bus.o_ovf},  {7'd0, ec.ovf});
         chk("comb_p",    {7'd0, bus.o_p},    {7'd0, ec.p});
         chk("comb_g",    {7'd0, bus.o_g},    {7'd0, ec.g});
      end
      if (bus.o_vld_q === 1'b1) begin
         if (reg_q.size() == 0) begin
            chk("reg_unexpected_vld", 8'd1, 8'd0);
         end else begin
            er = reg_q.pop_front();
            chk("reg_sum",  {4'd0, bus.o_sum_q},  {4'd0, er.sum});
            chk("reg_cout", {7'd0, bus.o_cout_q}, {7'd0, er.cout});
            chk("reg_ovf",  {7'd0, bus.o_ovf_q},  {7'd0, er.ovf});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      comb_t      exp;
   } dir_t;

   dir_t dir_tab[7];

   initial begin
      comb_t m;
      logic [3:0] ra, rb;
      logic       rc;
      n_vec = 0;
      n_err = 0;

      // sum, cout, ovf, p, g worked out by hand
      dir_tab[0] = '{4'd0,  4'd0,  1'b0, '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
      dir_tab[1] = '{4'd0,  4'd0,  1'b1, '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0}};
      dir_tab[2] = '{4'd15, 4'd15, 1'b1, '{4'd15, 1'b1, 1'b0, 1'b0, 1'b1}};
      dir_tab[3] = '{4'd15, 4'd0,  1'b1, '{4'd0,  1'b1, 1'b0, 1'b1, 1'b0}};
      dir_tab[4] = '{4'd7,  4'd1,  1'b0, '{4'd8,  1'b0, 1'b1, 1'b0, 1'b0}};
      dir_tab[5] = '{4'd8,  4'd8,  1'b0, '{4'd0,  1'b1, 1'b1, 1'b0, 1'b1}};
      dir_tab[6] = '{4'd5,  4'd10, 1'b1, '{4'd0,  1'b1, 1'b0, 1'b1, 1'b0}};

      // Reset held across an enabled edge: registers must stay cleared.
      rst_n     = 1'b0;
      bus.i_a   = 4'd9;
      bus.i_b   = 4'd9;
      bus.i_cin = 1'b0;
      bus.i_en  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sum_q",  {4'd0, bus.o_sum_q},  8'd0);
      chk("rst_cout_q", {7'd0, bus.o_cout_q}, 8'd0);
      chk("rst_ovf_q",  {7'd0, bus.o_ovf_q},  8'd0);
      chk("rst_vld_q",  {7'd0, bus.o_vld_q},  8'd0);
      chk("rst_comb_sum",  {4'd0, bus.o_sum},  8'd2);
      chk("rst_comb_cout", {7'd0, bus.o_cout}, 8'd1);
      bus.i_en = 1'b0;
      #2;
      rst_n = 1'b1;

      foreach (dir_tab[i])
         apply(dir_tab[i].a, dir_tab[i].b, dir_tab[i].cin, 1'b1, dir_tab[i].exp);

      for (int i = 0; i < 20; i++) begin
         ra = 4'($urandom_range(15));
         rb = 4'($urandom_range(15));
         rc = 1'($urandom_range(1));
         apply(ra, rb, rc, 1'b1, model(ra, rb, rc));
      end

      for (int i = 0; i < 512; i++) begin
         ra = 4'(i >> 5);
         rb = 4'(i >> 1);
         rc = 1'(i);
         apply(ra, rb, rc, 1'b1, model(ra, rb, rc));
      end

      // Registered stage: capture, hold with enable low, then async reset.
      apply(4'd9, 4'd9, 1'b0, 1'b1, '{4'd2, 1'b1, 1'b1, 1'b0, 1'b1});
      apply(4'd1, 4'd2, 1'b0, 1'b0, '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      chk("hold_vld_q",  {7'd0, bus.o_vld_q},  8'd0);
      chk("hold_sum_q",  {4'd0, bus.o_sum_q},  8'd2);
      chk("hold_cout_q", {7'd0, bus.o_cout_q}, 8'd1);
      chk("hold_ovf_q",  {7'd0, bus.o_ovf_q},  8'd1);
      bus.i_a = 4'd9;
      bus.i_b = 4'd9;
      comb_q.push_back('{4'd2, 1'b1, 1'b1, 1'b0, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sum_q",  {4'd0, bus.o_sum_q},  8'd0);
      chk("arst_cout_q", {7'd0, bus.o_cout_q}, 8'd0);
      chk("arst_ovf_q",  {7'd0, bus.o_ovf_q},  8'd0);
      chk("arst_vld_q",  {7'd0, bus.o_vld_q},  8'd0);
      chk("arst_comb_sum",  {4'd0, bus.o_sum},  8'd2);
      chk("arst_comb_cout", {7'd0, bus.o_cout}, 8'd1);
      #1;
      rst_n = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("drain_comb_q", 8'(comb_q.size()), 8'd0);
      chk("drain_reg_q",  8'(reg_q.size()),  8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
